// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand request side and result side.
// The master drives operands and out_ready; the slave (the adder) drives the rest.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, busy
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes one CHUNK-bit slice per clock, LSB first,
// with the inter-slice carry held in a register.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// CALC  | adding slice idx_q, one slice per clock
// DONE  | result held with out_valid=1 until out_ready
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      sh;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   slice_sum;
  logic             c_into_msb;

  always_comb begin
    sh         = 32'(idx_q) * CHUNK;
    a_shift    = a_q >> sh;
    b_shift    = b_q >> sh;
    a_slice    = a_shift[CHUNK-1:0];
    b_slice    = b_shift[CHUNK-1:0];
    slice_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ cin.
    c_into_msb = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = (sum_q & ~(SLICE_MASK << sh)) |
                  ((WIDTH'(slice_sum[CHUNK-1:0])) << sh);
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          c_out_d = slice_sum[CHUNK];
          ovf_d   = c_into_msb ^ slice_sum[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (WIDTH=16, CHUNK=4): vector table plus
// hand-written backpressure, mid-operation reset and back-to-back sequences.
module tb_seq_chunk_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();
  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, check latency and result, then hand it off.
  task automatic do_op(input string name, input vec_t v);
    int lat;
    chk({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = v.a; bus.b = v.b; bus.c_in = v.c_in; bus.sub = v.sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.c_in = ~v.c_in; bus.sub = ~v.sub;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " sum"},     32'(bus.sum), 32'(v.exp_sum));
    chk({name, " c_out"},   32'(bus.c_out), 32'(v.exp_cout));
    chk({name, " ovf"},     32'(bus.overflow), 32'(v.exp_ovf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
    chk({name, " in_ready rise"},  32'(bus.in_ready), 32'd1);
  endtask

  logic [15:0] b2b_a[4];
  logic [15:0] b2b_b[4];
  logic [15:0] b2b_exp[4];

  initial begin
    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    b2b_a   = '{16'h0001, 16'h1000, 16'hFFFF, 16'h0F0F};
    b2b_b   = '{16'h0002, 16'h2000, 16'hFFFF, 16'h00F1};
    b2b_exp = '{16'h0003, 16'h3000, 16'hFFFE, 16'h1000};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready",  32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset sum",       32'(bus.sum), 32'd0);
    chk("reset c_out",     32'(bus.c_out), 32'd0);
    chk("reset ovf",       32'(bus.overflow), 32'd0);
    chk("reset busy",      32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);
    chk("idle sum hold", 32'(bus.sum), 32'h0000);

    // Backpressure in DONE.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.c_in = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp out_valid %0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp sum %0d", i),       32'(bus.sum), 32'h3333);
      chk($sformatf("bp in_ready %0d", i),  32'(bus.in_ready), 32'd0);
      chk($sformatf("bp busy %0d", i),      32'(bus.busy), 32'd1);
      bus.in_valid = 1'b1; bus.a = 16'h4444; bus.b = 16'h4444;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    chk("bp sum after", 32'(bus.sum), 32'h3333);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp in_ready rise", 32'(bus.in_ready), 32'd1);
    chk("bp out_valid drop", 32'(bus.out_valid), 32'd0);
    chk("bp sum idle", 32'(bus.sum), 32'h3333);

    // Reset after slice 1 of an operation.
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst busy",      32'(bus.busy), 32'd0);
    chk("rst sum",       32'(bus.sum), 32'd0);
    chk("rst c_out",     32'(bus.c_out), 32'd0);
    chk("rst ovf",       32'(bus.overflow), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus.out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("rst no out_valid", 32'(seen), 32'd0);
    end
    do_op("post-rst", '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0});

    // Back-to-back with in_valid and out_ready held high.
    begin
      int k = 0, r = 0, cyc = 0, last_acc = 0;
      logic acc;
      bus.a = b2b_a[0]; bus.b = b2b_b[0]; bus.c_in = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      while (cyc < 60 && r < 4) begin
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
          chk($sformatf("b2b result %0d", r), 32'(bus.sum), 32'(b2b_exp[r]));
          r++;
        end
        @(posedge clk); #1;
        if (acc) begin
          if (k > 0) chk($sformatf("b2b interval %0d", k), 32'(cyc - last_acc), 32'd6);
          last_acc = cyc;
          k++;
          if (k < 4) begin
            bus.a = b2b_a[k]; bus.b = b2b_b[k];
          end else begin
            bus.in_valid = 1'b0;
          end
        end
        cyc++;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      chk("b2b accepts", 32'(k), 32'd4);
      chk("b2b results", 32'(r), 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
